// File: rtl/apg_seq_pkg.sv
// Shared types and constants for the APG shot sequencer: FSM states, APG status
// encodings, per-sample strobe pacing and the shot-length clamp helper.
package apg_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_WR_STB,
    ST_WR_GAP,
    ST_CHECK,
    ST_RUN,
    ST_WAIT_DONE,
    ST_WAIT_IDLE,
    ST_RD_CAP,
    ST_RD_OUT,
    ST_RD_STB,
    ST_RD_GAP,
    ST_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    APG_IDLE        = 2'd0,
    APG_TRANSACTION = 2'd1,
    APG_DONE        = 2'd2
  } apg_state_e;

  // Handshake + strobe + gap: one sample every three cycles at most.
  localparam int PACE_CYCLES = 3;

  function automatic logic [31:0] clamp_count(input logic [31:0] req, input logic [31:0] limit);
    return (req > limit) ? limit : req;
  endfunction

endpackage

// File: rtl/apg_sequencer_if.sv
// Bundle of the sequencer's control, stream and APG register-side signals.
// master = sequencer side, slave = stream source/sink plus APG side.
interface apg_sequencer_if #(
  parameter int NUM_SIG = 14
);
  logic               start;
  logic [31:0]        n_samples;
  logic               busy;
  logic               done;
  logic               error;
  logic [NUM_SIG-1:0] s_data;
  logic               s_valid;
  logic               s_ready;
  logic [NUM_SIG-1:0] m_data;
  logic               m_valid;
  logic               m_ready;
  logic               apg_clear;
  logic               apg_run;
  logic [7:0]         apg_control;
  logic [31:0]        apg_n_samples;
  logic [NUM_SIG-1:0] apg_write_channel;
  logic               apg_wr_strobe;
  logic               apg_rd_strobe;
  logic [NUM_SIG-1:0] apg_read_channel;
  logic [2:0]         apg_status;
  logic [31:0]        apg_write_buffer_len;

  modport master (
    input  start, n_samples, s_data, s_valid, m_ready,
           apg_read_channel, apg_status, apg_write_buffer_len,
    output busy, done, error, s_ready, m_data, m_valid,
           apg_clear, apg_run, apg_control, apg_n_samples,
           apg_write_channel, apg_wr_strobe, apg_rd_strobe
  );

  modport slave (
    output start, n_samples, s_data, s_valid, m_ready,
           apg_read_channel, apg_status, apg_write_buffer_len,
    input  busy, done, error, s_ready, m_data, m_valid,
           apg_clear, apg_run, apg_control, apg_n_samples,
           apg_write_channel, apg_wr_strobe, apg_rd_strobe
  );
endinterface

// File: rtl/apg_seq_strobe_pacer.sv
// Single-cycle strobe generator with a mandatory gap cycle afterwards, so the
// strobe can never be high on two consecutive cycles.
module apg_seq_strobe_pacer
  import apg_seq_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic go_i,
  output logic strobe_o,
  output logic ready_o
);

  localparam int PW = $clog2(PACE_CYCLES);

  logic [PW-1:0] phase_q;
  logic          strobe_q;

  assign ready_o  = (phase_q == '0);
  assign strobe_o = strobe_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      phase_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= go_i && ready_o;
      if (go_i && ready_o) begin
        phase_q <= PW'(PACE_CYCLES - 1);
      end else if (phase_q != '0) begin
        phase_q <= phase_q - PW'(1);
      end
    end
  end

endmodule

// File: rtl/apg_sequencer.sv
// Runs one APG shot: clear, paced sample load, run, wait, paced readback.
// Optional watchdog on the wait states is enabled by defining APG_SEQ_TIMEOUT_EN.
module apg_sequencer
  import apg_seq_pkg::*;
#(
  parameter int NUM_SIG  = 14,
  parameter int NUM_SAMP = 128
`ifdef APG_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 2**20
`endif
) (
  input  logic             axi_clk,
  input  logic             axi_resetn,
  apg_sequencer_if.master  bus
);

  localparam int PACE_WR = 0;
  localparam int PACE_RD = 1;

  seq_state_e         state_q;
  logic [31:0]        cnt_q, wr_cnt_q, rd_cnt_q;
  logic [31:0]        shot_cnt;
  logic               busy_q, done_q, error_q, s_ready_q, m_valid_q, clear_q, run_q;
  logic [NUM_SIG-1:0] m_data_q, wdata_q;
  logic [1:0]         pace_go, pace_strobe, pace_ready;
  logic               timeout;

  assign shot_cnt = clamp_count(bus.n_samples, 32'(NUM_SAMP));

  assign pace_go[PACE_WR] = (state_q == ST_LOAD) && s_ready_q && bus.s_valid
                            && pace_ready[PACE_WR];
  assign pace_go[PACE_RD] = (state_q == ST_RD_OUT) && m_valid_q && bus.m_ready
                            && pace_ready[PACE_RD] && (rd_cnt_q + 32'd1 != cnt_q);

  for (genvar gi = 0; gi < 2; gi++) begin : g_pacer
    apg_seq_strobe_pacer u_pacer (
      .clk_i    (axi_clk),
      .rst_ni   (axi_resetn),
      .go_i     (pace_go[gi]),
      .strobe_o (pace_strobe[gi]),
      .ready_o  (pace_ready[gi])
    );
  end

`ifdef APG_SEQ_TIMEOUT_EN
  logic [31:0] wdog_q;
  logic        in_wait;
  assign in_wait = (state_q == ST_WAIT_DONE) || (state_q == ST_WAIT_IDLE);
  always_ff @(posedge axi_clk) begin
    if (!axi_resetn || state_q == ST_RUN) begin
      wdog_q <= '0;
    end else if (in_wait) begin
      wdog_q <= wdog_q + 32'd1;
    end
  end
  assign timeout = in_wait && (wdog_q == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      clear_q   <= 1'b0;
      run_q     <= 1'b0;
      m_data_q  <= '0;
      wdata_q   <= '0;
    end else begin
      clear_q <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: if (bus.start) begin
          busy_q   <= 1'b1;
          error_q  <= 1'b0;
          cnt_q    <= shot_cnt;
          wr_cnt_q <= '0;
          rd_cnt_q <= '0;
          if (shot_cnt == '0) begin
            state_q <= ST_DONE;
          end else begin
            clear_q <= 1'b1;
            state_q <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          s_ready_q <= 1'b1;
          state_q   <= ST_LOAD;
        end
        ST_LOAD: if (pace_go[PACE_WR]) begin
          wdata_q   <= bus.s_data;
          s_ready_q <= 1'b0;
          state_q   <= ST_WR_STB;
        end
        ST_WR_STB: state_q <= ST_WR_GAP;
        ST_WR_GAP: begin
          wr_cnt_q <= wr_cnt_q + 32'd1;
          if (wr_cnt_q + 32'd1 == cnt_q) begin
            state_q <= ST_CHECK;
          end else begin
            s_ready_q <= 1'b1;
            state_q   <= ST_LOAD;
          end
        end
        // A short buffer means the APG lost a write; abandon before running.
        ST_CHECK: if (bus.apg_write_buffer_len != cnt_q) begin
          error_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end else begin
          run_q   <= 1'b1;
          state_q <= ST_RUN;
        end
        ST_RUN: state_q <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (bus.apg_status[1:0] == APG_DONE) state_q <= ST_WAIT_IDLE;
        ST_WAIT_IDLE: if (bus.apg_status == {1'b0, APG_IDLE}) state_q <= ST_RD_CAP;
        ST_RD_CAP: begin
          m_data_q  <= bus.apg_read_channel;
          m_valid_q <= 1'b1;
          state_q   <= ST_RD_OUT;
        end
        ST_RD_OUT: if (m_valid_q && bus.m_ready) begin
          m_valid_q <= 1'b0;
          rd_cnt_q  <= rd_cnt_q + 32'd1;
          state_q   <= (rd_cnt_q + 32'd1 == cnt_q) ? ST_DONE : ST_RD_STB;
        end
        ST_RD_STB: state_q <= ST_RD_GAP;
        ST_RD_GAP: state_q <= ST_RD_CAP;
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (timeout) begin
        error_q <= 1'b1;
        busy_q  <= 1'b0;
        clear_q <= 1'b1;
        state_q <= ST_IDLE;
      end
    end
  end

  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.error             = error_q;
  assign bus.s_ready           = s_ready_q;
  assign bus.m_data            = m_data_q;
  assign bus.m_valid           = m_valid_q;
  assign bus.apg_clear         = clear_q;
  assign bus.apg_run           = run_q;
  assign bus.apg_control       = 8'd0;
  assign bus.apg_n_samples     = cnt_q;
  assign bus.apg_write_channel = wdata_q;
  assign bus.apg_wr_strobe     = pace_strobe[PACE_WR];
  assign bus.apg_rd_strobe     = pace_strobe[PACE_RD];

endmodule
